// File: rtl/mux421_serializer_pkg.sv
// rtl/mux421_serializer_pkg.sv - shared encodings and sizes for the 4:1 mux serializer
// Contents: state_t (IDLE/SHIFT/GAP), LANES, SEL_W, BEAT_LAST.
package mux421_serializer_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] BEAT_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/mux421_serializer_mux.sv
// rtl/mux421_serializer_mux.sv - 4:1 mux, one data lane per select value
// Ports: data[LANES] lane inputs, sel lane select, y selected lane.
module mux421
  import mux421_serializer_pkg::*;
(
  input  logic [LANES-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = data[sel];

endmodule

// File: rtl/mux421_serializer.sv
// rtl/mux421_serializer.sv - steps a 4:1 mux select to serialize a parallel word
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/order_ovr/
// in_msb_first parallel input; sel, ser_data/ser_valid/ser_ready/ser_last serial
// output; busy high in SHIFT or GAP.
module mux421_serializer
  import mux421_serializer_pkg::*;
#(
  parameter int GAP_CYCLES        = 0,
  parameter bit MSB_FIRST_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_data,
  input  logic             order_ovr,
  input  logic             in_msb_first,
  output logic [SEL_W-1:0] sel,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  // GAP is entered with GAP_CYCLES-1 and left after the cycle at zero.
  localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [LANES-1:0] hold;
  logic             order;
  logic [SEL_W-1:0] beat;
  logic [3:0]       gap_cnt;

  logic last_beat_xfer;
  logic in_fire;
  logic load_order;

  assign last_beat_xfer = (state == SHIFT) && (beat == BEAT_LAST) && ser_ready;

  // Without a gap the next word may be taken on the last beat, so in_ready
  // must see ser_ready combinationally.
  assign in_ready   = (state == IDLE) || (last_beat_xfer && (GAP_CYCLES == 0));
  assign in_fire    = in_valid && in_ready;
  assign load_order = order_ovr ? in_msb_first : MSB_FIRST_DEFAULT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      order     <= 1'b0;
      sel       <= '0;
      beat      <= '0;
      gap_cnt   <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        SHIFT: begin
          if (ser_ready) begin
            if (beat != BEAT_LAST) begin
              beat     <= beat + 2'd1;
              sel      <= order ? sel - 2'd1 : sel + 2'd1;
              ser_last <= (beat == BEAT_LAST - 2'd1);
            end else if (GAP_CYCLES == 0) begin
              state     <= IDLE;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              gap_cnt   <= GAP_INIT;
              state     <= GAP;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // A load wins over the IDLE return above, giving back-to-back words.
      if (in_fire) begin
        hold      <= in_data;
        order     <= load_order;
        sel       <= load_order ? BEAT_LAST : 2'd0;
        beat      <= '0;
        state     <= SHIFT;
        ser_valid <= 1'b1;
        ser_last  <= 1'b0;
        busy      <= 1'b1;
      end
    end
  end

  mux421 u_mux (
    .data (hold),
    .sel  (sel),
    .y    (ser_data)
  );

endmodule

// File: tb/tb_mux421_serializer.sv
// tb/tb_mux421_serializer.sv - directed scoreboard bench for mux421_serializer
module tb_mux421_serializer;

  typedef struct packed {
    logic [1:0] sel;
    logic       data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       order_ovr;
  logic       in_msb_first;

  logic       in_valid, in_ready, ser_data, ser_valid, ser_ready, ser_last, busy;
  logic [1:0] sel;

  logic       in_valid3, in_ready3, ser_data3, ser_valid3, ser_ready3, ser_last3, busy3;
  logic [1:0] sel3;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   cyc;

  mux421_serializer #(.GAP_CYCLES(0), .MSB_FIRST_DEFAULT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .order_ovr(order_ovr), .in_msb_first(in_msb_first),
    .sel(sel), .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_last(ser_last), .busy(busy)
  );

  mux421_serializer #(.GAP_CYCLES(3), .MSB_FIRST_DEFAULT(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data), .order_ovr(order_ovr), .in_msb_first(in_msb_first),
    .sel(sel3), .ser_data(ser_data3), .ser_valid(ser_valid3), .ser_ready(ser_ready3),
    .ser_last(ser_last3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w, input logic msb);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      logic [1:0] s;
      s      = msb ? 2'(3 - i) : 2'(i);
      e.sel  = s;
      e.data = w[s];
      e.last = (i == 3);
      sb.push_back(e);
    end
  endtask

  // Compare dut0 against the scoreboard head; with nothing expected, no beat may appear.
  task automatic observe();
    if (sb.size() == 0) begin
      chk("no_extra_beat", ser_valid, 1'b0);
    end else if (ser_valid) begin
      chk("beat_sel", sel, sb[0].sel);
      chk("beat_data", ser_data, sb[0].data);
      chk("beat_last", ser_last, sb[0].last);
      if (ser_ready) void'(sb.pop_front());
    end
  endtask

  task automatic one_cycle();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int limit, output int n);
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      one_cycle();
      n++;
    end
    chk("drain_bound", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; in_data = 4'h0;
    order_ovr = 1'b0; in_msb_first = 1'b0; ser_ready = 1'b1; ser_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_ser_last", ser_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // LSB first, default order
    in_data = 4'b1011; order_ovr = 1'b0; in_valid = 1'b1;
    push_word(4'b1011, 1'b0);
    one_cycle();
    in_valid = 1'b0;
    run_until_empty(20, cyc);
    chk("lsb_cycles", cyc, 4);
    one_cycle();

    // MSB first via override
    in_data = 4'b1011; order_ovr = 1'b1; in_msb_first = 1'b1; in_valid = 1'b1;
    push_word(4'b1011, 1'b1);
    one_cycle();
    in_valid = 1'b0;
    run_until_empty(20, cyc);
    chk("msb_cycles", cyc, 4);
    one_cycle();

    // Stall on beat 2
    in_data = 4'b0110; order_ovr = 1'b0; in_valid = 1'b1;
    push_word(4'b0110, 1'b0);
    one_cycle();
    in_valid = 1'b0;
    one_cycle();
    one_cycle();
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_sel", sel, 2'd2);
      chk("stall_data", ser_data, 1'b1);
      one_cycle();
    end
    chk("stall_pending", sb.size(), 2);
    ser_ready = 1'b1;
    run_until_empty(20, cyc);
    chk("stall_resume_cycles", cyc, 2);
    repeat (3) one_cycle();

    // Back-to-back words with no gap
    in_data = 4'hA; in_valid = 1'b1;
    push_word(4'hA, 1'b0);
    one_cycle();
    in_data = 4'h5;
    push_word(4'h5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b2b_valid", ser_valid, 1'b1);
      chk("b2b_in_ready", in_ready, 32'(i == 3 || i == 7));
      one_cycle();
      if (i == 3) in_valid = 1'b0;
    end
    chk("b2b_drained", sb.size(), 0);
    one_cycle();

    // Gap of 3 cycles on the second instance
    order_ovr = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      logic [3:0] w;
      int idx;
      if (c == 0) begin in_data = 4'h9; in_valid3 = 1'b1; end
      if (c == 1) in_data = 4'h6;
      if (c == 9) in_valid3 = 1'b0;
      #1;
      chk("gap_ser_valid", ser_valid3, 32'((c >= 1 && c <= 4) || (c >= 9)));
      chk("gap_in_ready", in_ready3, 32'(c == 0 || c == 8));
      chk("gap_busy", busy3, 32'((c >= 1 && c <= 7) || (c >= 9)));
      chk("gap_ser_last", ser_last3, 32'(c == 4 || c == 12));
      if ((c >= 1 && c <= 4) || c >= 9) begin
        w   = (c <= 4) ? 4'h9 : 4'h6;
        idx = (c <= 4) ? c - 1 : c - 9;
        chk("gap_ser_data", ser_data3, w[idx]);
        chk("gap_sel", sel3, idx);
      end
      one_cycle();
    end

    // Reset during beat 1
    in_data = 4'b1101; order_ovr = 1'b0; in_valid = 1'b1;
    push_word(4'b1101, 1'b0);
    one_cycle();
    in_valid = 1'b0;
    one_cycle();
    #1;
    chk("pre_rst_valid", ser_valid, 1'b1);
    chk("pre_rst_sel", sel, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ser_valid, 1'b0);
    chk("async_rst_sel", sel, 2'd0);
    chk("async_rst_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (6) one_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
